// File: rtl/sipo_rx.sv
// +--------------------------------------------------------------------------+
// | sipo_rx: MSB-first serial-in/parallel-out receiver with sof framing,     |
// | valid/ready output holding register and sticky overrun reporting.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sipo_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             frame_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  // Only WIDTH-1 bits are stored: the final bit goes straight into dout.
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic             done;

  assign word_next = {shreg, sin};
  assign done      = (state == SHIFT) && sin_en && !sof &&
                     (bit_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (ovr_clr) overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (sin_en && sof) begin
            shreg   <= (WIDTH - 1)'(sin);
            bit_cnt <= CNT_W'(1);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (sin_en) begin
            if (sof) begin
              shreg     <= (WIDTH - 1)'(sin);
              bit_cnt   <= CNT_W'(1);
              frame_err <= 1'b1;
            end else if (done) begin
              shreg   <= '0;
              bit_cnt <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              shreg   <= word_next[WIDTH-2:0];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A completed word may only displace dout if it is empty or leaving now;
      // the overrun set sits after the clear so a simultaneous set wins.
      if (done) begin
        if (!dout_valid || dout_ready) begin
          dout       <= word_next;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx.sv
// +--------------------------------------------------------------------------+
// | tb_sipo_rx: directed + random bench for sipo_rx against a queue model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sipo_rx;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sin = 1'b0;
  logic             sin_en = 1'b0;
  logic             sof = 1'b0;
  logic             dout_ready = 1'b0;
  logic             ovr_clr = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the word in progress, plus the output register.
  bit      cur[$];
  int      m_dout;
  bit      m_valid;
  bit      m_ovr;
  bit      m_ferr;

  sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_en     (sin_en),
    .sof        (sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    m_dout  = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  // One clock edge of behaviour, computed from the inputs present at the edge.
  task automatic model_edge();
    bit done  = 1'b0;
    bit set_o = 1'b0;
    int word  = 0;
    m_ferr = 1'b0;
    if (sin_en) begin
      if (sof) begin
        if (cur.size() > 0) m_ferr = 1'b1;
        cur.delete();
        cur.push_back(sin);
      end else if (cur.size() > 0) begin
        cur.push_back(sin);
        if (cur.size() == WIDTH) begin
          foreach (cur[i]) word = word * 2 + int'(cur[i]);
          done = 1'b1;
          cur.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || dout_ready) begin
        m_dout  = word;
        m_valid = 1'b1;
      end else begin
        set_o = 1'b1;
      end
    end else if (m_valid && dout_ready) begin
      m_valid = 1'b0;
    end
    if (set_o) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
  endtask

  task automatic compare_all();
    chk("dout",       32'(dout),       32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("busy",       32'(busy),       32'(cur.size() > 0));
    chk("bit_cnt",    32'(bit_cnt),    32'(cur.size()));
    chk("overrun",    32'(overrun),    32'(m_ovr));
    chk("frame_err",  32'(frame_err),  32'(m_ferr));
  endtask

  task automatic step(input logic s, input logic e, input logic f,
                      input logic r, input logic c);
    sin = s; sin_en = e; sof = f; dout_ready = r; ovr_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Send one word MSB first; ready is r_last on the final bit, r elsewhere.
  task automatic send(input logic [WIDTH-1:0] v, input int gap,
                      input logic r, input logic r_last);
    for (int i = 0; i < WIDTH; i++) begin
      step(v[WIDTH-1-i], 1'b1, i == 0, (i == WIDTH - 1) ? r_last : r, 1'b0);
      if (i < WIDTH - 1)
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, r, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    rst = 1'b0;
    @(posedge clk); #1;
    compare_all();

    // Basic word with consumer ready: valid lasts exactly one cycle.
    send(4'b1010, 0, 1'b1, 1'b1);
    chk("t1_dout", 32'(dout), 32'hA);
    chk("t1_valid", 32'(dout_valid), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_valid_drop", 32'(dout_valid), 32'd0);

    // Gaps between bits; bit_cnt holds through them.
    send(4'b1101, 2, 1'b1, 1'b1);
    chk("t2_dout", 32'(dout), 32'hD);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun while output is held, then drain and clear.
    send(4'hA, 0, 1'b0, 1'b0);
    send(4'hD, 0, 1'b0, 1'b0);
    chk("t3_dout_held", 32'(dout), 32'hA);
    chk("t3_overrun", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_consumed", 32'(dout_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovr_clr", 32'(overrun), 32'd0);
    send(4'h5, 0, 1'b1, 1'b1);
    chk("t3_next", 32'(dout), 32'h5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Resync mid-word: partial "10" is dropped, frame_err pulses.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_ferr", 32'(frame_err), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_ferr_pulse", 32'(frame_err), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_dout", 32'(dout), 32'h6);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-word, away from any clock edge.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("t5_bitcnt_rst", 32'(bit_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_ignored", 32'(bit_cnt), 32'd0);

    // Completion on the same edge the held word is transferred.
    send(4'h9, 0, 1'b0, 1'b0);
    send(4'h3, 0, 1'b0, 1'b1);
    chk("t6_dout", 32'(dout), 32'h3);
    chk("t6_valid", 32'(dout_valid), 32'd1);
    chk("t6_ovr", 32'(overrun), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++)
      step(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
           1'($urandom), ($urandom_range(0, 9) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
Serial-in/parallel-out receiver. It is the far end of the team's 4-bit PISO shift-register link. It collects an MSB-first serial bit stream into WIDTH-bit words, framed by a start-of-frame marker. Completed words are presented on a parallel valid/ready output. A bit counter, a framing state machine, an output holding register and sticky error reporting are included so the PISO can run back-to-back into a downstream consumer.

Parameters:
WIDTH, 4, word length in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, do not override.

Ports:
clk  input  1  rising-edge clock for all state.
rst  input  1  asynchronous, active-high reset; clears all state immediately.
sin  input  1  serial data bit, sampled only when sin_en=1.
sin_en  input  1  bit strobe: one serial bit is presented this cycle.
sof  input  1  start of frame: qualifies the current sin_en bit as the MSB of a new word; ignored when sin_en=0.
dout  output  WIDTH  received word, MSB = first bit received.
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  consumer accepts dout this cycle.
busy  output  1  a word is partially assembled (state SHIFT).
bit_cnt  output  CNT_W  number of bits of the current word captured so far.
overrun  output  1  sticky: a completed word was dropped because the output was still occupied.
ovr_clr  input  1  synchronous clear of overrun.
frame_err  output  1  one-cycle pulse: sof arrived while a word was partially assembled.

Behaviour:
- Reset values: dout=0, dout_valid=0, busy=0, bit_cnt=0, overrun=0, frame_err=0, shift register=0, state=IDLE.
- Reset mid-word discards the partial word and any pending dout; no word is emitted.
- Bit order: shift register shifts left; each new bit enters at bit 0, so the first bit received ends up at dout[WIDTH-1].
- State IDLE:
  - sin_en=1 with sof=0: bit is ignored.
  - sin_en=1 with sof=1: capture sin, set bit_cnt=1, go to SHIFT.
- State SHIFT:
  - sin_en=0: hold all state; gaps of any length are legal.
  - sin_en=1 with sof=0: shift in sin and increment bit_cnt.
  - When the bit that makes bit_cnt reach WIDTH is captured, the word is complete. Return to IDLE with bit_cnt=0 in the same edge.
  - sin_en=1 with sof=1: resync. Discard the partial word, capture sin as the new MSB, set bit_cnt=1, stay in SHIFT, and pulse frame_err for one cycle.
- busy = (state==SHIFT).
- Word completion latency: dout/dout_valid update on the same clock edge that captures the last bit. dout_valid is visible the cycle after the last sin_en cycle.
- Output handshake:
  - A transfer occurs on any edge where dout_valid=1 and dout_ready=1.
  - After a transfer, dout_valid falls on that edge unless a new word loads on the same edge.
  - dout keeps its last value after consumption.
  - dout and dout_valid must not change while dout_valid=1 and dout_ready=0, except by reset.
- Completion load rule: the completed word loads into dout with dout_valid=1 if dout_valid=0, or if a transfer occurs on that same edge.
- Completion with output occupied (dout_valid=1, dout_ready=0): the new word is dropped, dout is unchanged, and overrun is set.
- overrun:
  - Stays set until ovr_clr=1 or reset.
  - If ovr_clr and a new overrun occur on the same edge, set wins.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=4. Reset, then sof=1 on the first of 4 consecutive sin_en cycles with sin=1,0,1,0 and dout_ready=1 -> dout=4'b1010, dout_valid high for exactly one cycle, starting the cycle after the 4th bit; busy high during bits 2-4 and low afterwards.
- Send 1,1,0,1 with 2-cycle sin_en gaps between bits -> dout=4'b1101; bit_cnt steps 1,2,3 and holds through the gaps.
- dout_ready=0; send 4'hA, then 4'hD -> dout stays 4'hA with dout_valid=1 and overrun=1. Then pulse dout_ready -> 4'hA consumed. Then pulse ovr_clr -> overrun=0. Next word 4'h5 is received normally.
- Send 1,0 and then assert sof with a new bit, followed by 3 more bits forming 4'b0110 -> frame_err pulses once and dout=4'b0110; the partial "10" is never output.
- Send 2 bits, assert rst asynchronously between clock edges -> all outputs zero immediately. Bits without sof after rst deassertion are ignored; bit_cnt stays 0.
- dout_valid=1 with dout_ready=1 on the same edge that a new word completes -> old word transferred, new word loaded, dout_valid stays 1, overrun stays 0.
